// File: rtl/r_pkg.sv
// Shared definitions for the 1x4 router packet path.
// Holds the transmitter state encoding, header layout constants, the header
// packing helper and the running-parity helper shared with the router.
package r_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned MAX_LEN     = 63;
    localparam int unsigned LEN_W       = 6;
    localparam int unsigned HDR_ADDR_W  = 2;
    localparam int unsigned HDR_LEN_MSB = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY
    } tx_state_t;

    // Header byte: length in the upper bits, destination port in the lower bits.
    function automatic logic [HDR_LEN_MSB:0] hdr_pack(input logic [LEN_W-1:0]      len,
                                                      input logic [HDR_ADDR_W-1:0] addr);
        logic [HDR_LEN_MSB:0] h;
        h                          = '0;
        h[HDR_LEN_MSB:HDR_ADDR_W]  = len;
        h[HDR_ADDR_W-1:0]          = addr;
        return h;
    endfunction

    // One step of the packet parity (XOR over header and payload bytes).
    function automatic logic [DATA_W-1:0] par_step(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/r_tx_buf.sv
// Payload staging buffer for r_pkt_tx.
// DEPTH x DATA_W register file written sequentially at the fill count,
// read asynchronously by index; count is cleared synchronously when a packet
// has been consumed.
//  clk, reset      clock, synchronous active-high reset (clears count only)
//  wr_en_i/wr_data_i  append one byte (ignored when full)
//  clr_i           drop all staged bytes
//  rd_addr_i/rd_data_o  async read port
//  count_o         bytes currently staged; count_d_o is its next value
module r_tx_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 63,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              clr_i,
    input  logic [CNT_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  count_d_o
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              wr_ok;

    assign wr_ok = wr_en_i && (count_q < DEPTH_C);

    // Next fill count; clear takes priority over an append.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (wr_ok) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only bytes below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr_i) begin
            mem_q[count_q] <= wr_data_i;
        end
    end

    assign rd_data_o = (rd_addr_i < DEPTH_C) ? mem_q[rd_addr_i] : '0;
    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/r_pkt_tx.sv
// Packet transmitter feeding the 1x4 router input port.
// Bytes are staged through wr_en/wr_data while idle; an accepted start sends
// header {len,addr}, the first len staged bytes, then the XOR parity byte.
// A byte advances only on an edge with busy low, otherwise everything holds.
//  wr_en/wr_data/wr_ready        payload staging
//  start/start_addr/start_len/start_ready  packet request
//  busy                           router back-pressure
//  pkt_valid/data_out             byte stream to router
//  tx_done                        pulse when parity byte is accepted
//  err                            pulse on a start with invalid length
module r_pkt_tx #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_LEN = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              start,
    input  logic [1:0]        start_addr,
    input  logic [5:0]        start_len,
    output logic              start_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_done,
    output logic              err
);
    import r_pkg::tx_state_t;
    import r_pkg::ST_IDLE;
    import r_pkg::ST_HEADER;
    import r_pkg::ST_PAYLOAD;
    import r_pkg::ST_PARITY;
    import r_pkg::hdr_pack;
    import r_pkg::par_step;

    localparam int unsigned      LEN_W   = r_pkg::LEN_W;
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              tx_done_q, tx_done_d;
    logic              err_q, err_d;
    logic              wr_ready_q, wr_ready_d;
    logic              start_ready_q, start_ready_d;

    logic              buf_wr_c;
    logic              buf_clr_c;
    logic [LEN_W-1:0]  rd_addr_c;
    logic [DATA_W-1:0] rd_data;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  count_d;
    logic              accept_c;
    logic [DATA_W-1:0] hdr_c;

    r_tx_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .CNT_W  (LEN_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (buf_wr_c),
        .wr_data_i (wr_data),
        .clr_i     (buf_clr_c),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (rd_data),
        .count_o   (count),
        .count_d_o (count_d)
    );

    assign accept_c = (state_q != ST_IDLE) && !busy;
    assign hdr_c    = DATA_W'(hdr_pack(start_len, start_addr));

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        parity_d    = parity_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        tx_done_d   = 1'b0;
        err_d       = 1'b0;
        buf_wr_c    = 1'b0;
        buf_clr_c   = 1'b0;
        rd_addr_c   = '0;

        case (state_q)
            ST_IDLE: begin
                buf_wr_c = wr_en && wr_ready_q;
                // Length check uses the count before any same-cycle write.
                if (start) begin
                    if ((start_len != '0) && (start_len <= count)) begin
                        state_d     = ST_HEADER;
                        len_d       = start_len;
                        data_out_d  = hdr_c;
                        parity_d    = hdr_c;
                        pkt_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                rd_addr_c = '0;
                if (accept_c) begin
                    state_d    = ST_PAYLOAD;
                    idx_d      = '0;
                    data_out_d = rd_data;
                end
            end
            ST_PAYLOAD: begin
                rd_addr_c = idx_q + LEN_W'(1);
                if (accept_c) begin
                    parity_d = par_step(parity_q, data_out_q);
                    if (idx_q == (len_q - LEN_W'(1))) begin
                        state_d     = ST_PARITY;
                        pkt_valid_d = 1'b0;
                        data_out_d  = par_step(parity_q, data_out_q);
                    end else begin
                        idx_d      = idx_q + LEN_W'(1);
                        data_out_d = rd_data;
                    end
                end
            end
            ST_PARITY: begin
                if (accept_c) begin
                    state_d     = ST_IDLE;
                    tx_done_d   = 1'b1;
                    buf_clr_c   = 1'b1;
                    data_out_d  = '0;
                    pkt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_ready_d = (state_d == ST_IDLE);
        wr_ready_d    = (state_d == ST_IDLE) && (count_d < MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            parity_q      <= '0;
            data_out_q    <= '0;
            pkt_valid_q   <= 1'b0;
            tx_done_q     <= 1'b0;
            err_q         <= 1'b0;
            wr_ready_q    <= 1'b1;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            parity_q      <= parity_d;
            data_out_q    <= data_out_d;
            pkt_valid_q   <= pkt_valid_d;
            tx_done_q     <= tx_done_d;
            err_q         <= err_d;
            wr_ready_q    <= wr_ready_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign start_ready = start_ready_q;
    assign pkt_valid   = pkt_valid_q;
    assign data_out    = data_out_q;
    assign tx_done     = tx_done_q;
    assign err         = err_q;

endmodule
